// File: rtl/ad_uart_pkg.sv
// ad_uart_pkg: shared definitions for the AD sample -> UART path.
// Holds the drain FSM state type and the ASCII codes also used by the
// polling controller for its line terminators.
package ad_uart_pkg;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_CAP     = 3'd2,
        ST_SEND    = 3'd3,
        ST_GAP     = 3'd4,
        ST_SEND_HI = 3'd5,
        ST_SEND_LO = 3'd6
    } drain_state_e;

    // Line terminators always travel as a single raw character.
    function automatic logic is_terminator(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// hex_nibble_to_ascii: combinational nibble -> uppercase ASCII hex digit.
// Ports:
//   i_nibble   in  4  value 0..15
//   o_ascii_c  out 8  '0'..'9' (8'h30..8'h39) or 'A'..'F' (8'h41..8'h46)
module hex_nibble_to_ascii
    import ad_uart_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii_c
);

    always_comb begin
        o_ascii_c = ASCII_ZERO + 8'(i_nibble);
        if (i_nibble > 4'd9) begin
            o_ascii_c = ASCII_UPPER_A + 8'(i_nibble - 4'd10);
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: reads the 8-bit AD sample FIFO one byte at a time and
// hands each byte to the UART transmitter over valid/ready, with optional
// idle gap after each byte. At most one byte is ever read ahead of the UART.
// Build option: define FIFO_UART_HEX_ASCII_EN to send each sample as two
// uppercase ASCII hex characters (CR/LF bytes still go out raw).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   enable               level, permits starting a new byte
//   fifo_empty, fifo_q   FIFO status and read data (q valid cycle after rdreq)
//   fifo_rdreq           one-cycle read pulse per byte
//   tx_valid, tx_data    byte offered to the UART
//   tx_ready             UART accepts
//   busy                 FSM not idle
//   tx_count             accepted UART characters, wraps modulo 2^CNT_W
module fifo_uart_drain
    import ad_uart_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_q,
    output logic             fifo_rdreq,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] tx_count
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

    drain_state_e     r_state;
    drain_state_e     w_state_nx;
    drain_state_e     w_after_send;
    logic             r_fifo_rdreq, w_rdreq_nx;
    logic             r_tx_valid,   w_valid_nx;
    logic [7:0]       r_tx_data,    w_data_nx;
    logic             r_busy;
    logic [CNT_W-1:0] r_tx_count,   w_count_nx;
    logic [GAP_W-1:0] r_gap_cnt,    w_gap_nx;
    logic             w_accept;

`ifdef FIFO_UART_HEX_ASCII_EN
    logic [3:0] r_lo_nib, w_lo_nib_nx;
    logic [7:0] w_hi_ascii;
    logic [7:0] w_lo_ascii;

    // High digit comes straight from the FIFO in CAP; low digit from the held nibble.
    hex_nibble_to_ascii u_hex_hi (.i_nibble(fifo_q[7:4]), .o_ascii_c(w_hi_ascii));
    hex_nibble_to_ascii u_hex_lo (.i_nibble(r_lo_nib),    .o_ascii_c(w_lo_ascii));
`endif

    assign w_accept     = r_tx_valid && tx_ready;
    assign w_after_send = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx  = r_state;
        w_rdreq_nx  = 1'b0;
        w_valid_nx  = r_tx_valid;
        w_data_nx   = r_tx_data;
        w_gap_nx    = r_gap_cnt;
        w_count_nx  = r_tx_count + CNT_W'(w_accept);
`ifdef FIFO_UART_HEX_ASCII_EN
        w_lo_nib_nx = r_lo_nib;
`endif
        case (r_state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    w_state_nx = ST_RD;
                    w_rdreq_nx = 1'b1;
                end
            end
            ST_RD: begin
                w_state_nx = ST_CAP;
            end
            ST_CAP: begin
                w_valid_nx = 1'b1;
`ifdef FIFO_UART_HEX_ASCII_EN
                w_lo_nib_nx = fifo_q[3:0];
                if (is_terminator(fifo_q)) begin
                    w_data_nx  = fifo_q;
                    w_state_nx = ST_SEND;
                end else begin
                    w_data_nx  = w_hi_ascii;
                    w_state_nx = ST_SEND_HI;
                end
`else
                w_data_nx  = fifo_q;
                w_state_nx = ST_SEND;
`endif
            end
`ifdef FIFO_UART_HEX_ASCII_EN
            ST_SEND_HI: begin
                // tx_valid stays high straight into the low digit.
                if (w_accept) begin
                    w_data_nx  = w_lo_ascii;
                    w_state_nx = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (w_accept) begin
                    w_valid_nx = 1'b0;
                    w_gap_nx   = '0;
                    w_state_nx = w_after_send;
                end
            end
`endif
            ST_SEND: begin
                if (w_accept) begin
                    w_valid_nx = 1'b0;
                    w_gap_nx   = '0;
                    w_state_nx = w_after_send;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any captured byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fifo_rdreq <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_tx_count   <= '0;
            r_gap_cnt    <= '0;
`ifdef FIFO_UART_HEX_ASCII_EN
            r_lo_nib     <= 4'h0;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_fifo_rdreq <= w_rdreq_nx;
            r_tx_valid   <= w_valid_nx;
            r_tx_data    <= w_data_nx;
            r_busy       <= (w_state_nx != ST_IDLE);
            r_tx_count   <= w_count_nx;
            r_gap_cnt    <= w_gap_nx;
`ifdef FIFO_UART_HEX_ASCII_EN
            r_lo_nib     <= w_lo_nib_nx;
`endif
        end
    end

    assign fifo_rdreq = r_fifo_rdreq;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;
    assign tx_count   = r_tx_count;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: randomized bench for fifo_uart_drain. A queue models
// the FIFO; the expected UART character stream is built from the bytes the
// DUT pops, expanded by the stream rules (raw, or hex with CR/LF raw).
`timescale 1ns/1ps
module tb_fifo_uart_drain;

    localparam int unsigned TB_GAP   = 3;
    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic                fifo_empty = 1'b1;
    logic [7:0]          fifo_q = 8'h00;
    logic                tx_ready = 1'b0;
    logic                fifo_rdreq;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                busy;
    logic [TB_CNT_W-1:0] tx_count;

    fifo_uart_drain #(.GAP_CYCLES(TB_GAP), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .tx_count(tx_count)
    );

    always #10 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_total = 0;
    logic [7:0] fifo_mem[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rd_cyc[$];
    int         val_cyc[$];
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic int n_chars(input logic [7:0] b);
`ifdef FIFO_UART_HEX_ASCII_EN
        return (b == 8'h0D || b == 8'h0A) ? 1 : 2;
`else
        return 1;
`endif
    endfunction

    function automatic void push_exp(input logic [7:0] b);
        if (n_chars(b) == 1) begin
            exp_q.push_back(b);
        end else begin
            exp_q.push_back(hex_char(b[7:4]));
            exp_q.push_back(hex_char(b[3:0]));
        end
        exp_total += n_chars(b);
    endfunction

    // FIFO model: q appears the cycle after rdreq.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rdreq && fifo_mem.size() > 0) begin
            fifo_q <= fifo_mem[0];
            void'(fifo_mem.pop_front());
        end
        fifo_empty <= (fifo_mem.size() == 0);
    end

    // Observer, away from the active edge; inputs only change at posedge+1.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            got_q.delete();
            exp_total = 0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (fifo_rdreq) begin
                check_eq("rd_while_empty", 32'(fifo_empty), 32'd0);
                rd_cyc.push_back(cyc);
                if (fifo_mem.size() > 0) push_exp(fifo_mem[0]);
            end
            if (prev_stall) begin
                check_eq("hold_valid", 32'(tx_valid), 32'd1);
                check_eq("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && !prev_valid) val_cyc.push_back(cyc);
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_valid = tx_valid;
            prev_data  = tx_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_drained(input string tag, input int budget, input logic rand_ready);
        int n = 0;
        while (!(fifo_empty && !busy) && n < budget) begin
            if (rand_ready) tx_ready = ($urandom_range(0, 2) != 0);
            tick(1);
            n++;
        end
        tx_ready = 1'b1;
        tick(2);
        if (n >= budget) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rdreq(input string tag, input int budget);
        int n = 0;
        while (!fifo_rdreq && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq($sformatf("%s_chr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check_eq({tag, "_count"}, 32'(tx_count), 32'(TB_CNT_W'(exp_total)));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] s1 [4];
        logic [7:0] b;
        int         c0;

        s1[0] = 8'h5A; s1[1] = 8'h0D; s1[2] = 8'h0A; s1[3] = 8'h3F;

        tick(3);
        check_eq("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'h00);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(tx_count), 32'd0);

        // Back-to-back bytes with ready high: latency, pacing and stream.
        reset = 1'b0; enable = 1'b1; tx_ready = 1'b1;
        tick(2);
        rd_cyc.delete(); val_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 4; i++) push(s1[i]);
        wait_drained("s1", 200, 1'b0);
        check_eq("s1_rd_pulses", 32'(rd_cyc.size()), 32'd4);
        if (rd_cyc.size() > 0) check_eq("s1_rd_latency", 32'(rd_cyc[0] - c0), 32'd1);
        if (val_cyc.size() > 0) check_eq("s1_valid_latency", 32'(val_cyc[0] - c0), 32'd3);
        for (int i = 0; i + 1 < rd_cyc.size() && i < 3; i++) begin
            check_eq($sformatf("s1_period%0d", i), 32'(rd_cyc[i+1] - rd_cyc[i]),
                     32'(3 + n_chars(s1[i]) + TB_GAP));
        end
        compare_stream("s1");
        check_eq("s1_empty", 32'(fifo_empty), 32'd1);
        check_eq("s1_busy", 32'(busy), 32'd0);

        // Backpressure: ready low for 10 cycles while a byte is offered.
        rd_cyc.delete();
        tx_ready = 1'b0;
        push(8'hC3);
        wait_valid("s2", 50);
        check_eq("s2_first_chr", 32'(tx_data), 32'(n_chars(8'hC3) == 1 ? 8'hC3 : hex_char(4'hC)));
        tick(10);
        check_eq("s2_still_valid", 32'(tx_valid), 32'd1);
        check_eq("s2_no_accept", 32'(got_q.size()), 32'd0);
        tx_ready = 1'b1;
        wait_drained("s2", 100, 1'b0);
        check_eq("s2_rd_pulses", 32'(rd_cyc.size()), 32'd1);
        compare_stream("s2");

        // Enable dropped the cycle after RD: one byte finishes, no more reads.
        rd_cyc.delete();
        for (int i = 0; i < 4; i++) push(8'(8'h10 * i + 8'h07));
        wait_rdreq("s3", 50);
        tick(1);
        enable = 1'b0;
        tick(30);
        check_eq("s3_rd_pulses", 32'(rd_cyc.size()), 32'd1);
        check_eq("s3_fifo_left", 32'(fifo_mem.size()), 32'd3);
        check_eq("s3_busy", 32'(busy), 32'd0);
        compare_stream("s3");

        // Random bytes, random ready and enable; count wraps at 2^TB_CNT_W.
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            push(b);
        end
        for (int k = 0; k < 300; k++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 9) != 0);
            tick(1);
        end
        enable = 1'b1;
        wait_drained("s4", 3000, 1'b1);
        compare_stream("s4");
        check_eq("s4_empty", 32'(fifo_empty), 32'd1);

        // Reset while a byte is being offered: byte discarded, next one drains.
        tx_ready = 1'b0;
        push(8'hA5);
        push(8'h0A);
        wait_valid("s5", 50);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_eq("s5_valid", 32'(tx_valid), 32'd0);
        check_eq("s5_count", 32'(tx_count), 32'd0);
        check_eq("s5_busy", 32'(busy), 32'd0);
        check_eq("s5_fifo_left", 32'(fifo_mem.size()), 32'd1);
        reset = 1'b0;
        tx_ready = 1'b1;
        wait_drained("s5", 100, 1'b0);
        compare_stream("s5");
        check_eq("s5_final_count", 32'(tx_count), 32'(n_chars(8'h0A)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
